// File: rtl/sccb_target.sv
// SCCB/I2C target (camera-side responder) for the OV7670 init bus.
// Oversamples SIOC/SIOD in the i_clk domain and decodes 3-phase writes
// (ID, sub-address, data) and 2-phase single-byte reads. ACK and read data
// are driven open-drain through o_siod_oe. Register accesses are presented
// to a local register file as single-cycle pulses.
module sccb_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sioc,
    input  logic       i_siod,
    output logic       o_siod_oe,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_rd_req,
    input  logic [7:0] i_rd_data,
    output logic       o_busy,
    output logic       o_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_SUB, S_SUB_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_MACK, S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_sioc_sync, r_siod_sync;
    logic                   r_sioc_hist, r_siod_hist;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_rw;
    logic       r_siod_oe;
    logic       r_wr_valid;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_rd_req;
    logic       r_busy;
    logic       r_err;

    logic       w_sioc, w_siod;
    logic       w_sioc_rise, w_sioc_fall;
    logic       w_start, w_stop;
    logic [7:0] w_byte;

    // Synchronizer chains plus one history flop; idle bus level is high so
    // reset never manufactures a START/STOP out of the pipeline contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sioc_sync <= '1;
            r_siod_sync <= '1;
            r_sioc_hist <= 1'b1;
            r_siod_hist <= 1'b1;
        end else begin
            r_sioc_sync <= {r_sioc_sync[SYNC_STAGES-2:0], i_sioc};
            r_siod_sync <= {r_siod_sync[SYNC_STAGES-2:0], i_siod};
            r_sioc_hist <= r_sioc_sync[SYNC_STAGES-1];
            r_siod_hist <= r_siod_sync[SYNC_STAGES-1];
        end
    end

    assign w_sioc      = r_sioc_sync[SYNC_STAGES-1];
    assign w_siod      = r_siod_sync[SYNC_STAGES-1];
    assign w_sioc_rise = w_sioc & ~r_sioc_hist;
    assign w_sioc_fall = ~w_sioc & r_sioc_hist;
    // START/STOP need SIOC high on both the current and previous sample.
    assign w_start     = w_sioc & r_sioc_hist & r_siod_hist & ~w_siod;
    assign w_stop      = w_sioc & r_sioc_hist & ~r_siod_hist & w_siod;
    assign w_byte      = {r_shift[6:0], w_siod};

    // Protocol FSM: START/STOP first, then read-data capture, then SIOC edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_rw       <= 1'b0;
            r_siod_oe  <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 8'h00;
            r_wr_data  <= 8'h00;
            r_rd_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_valid <= 1'b0;
            r_rd_req   <= 1'b0;
            r_err      <= 1'b0;
            if (w_start) begin
                r_state   <= S_DEV;
                r_bit_cnt <= 4'd0;
                r_busy    <= 1'b1;
                r_siod_oe <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                r_busy    <= 1'b0;
                r_siod_oe <= 1'b0;
            end else if (r_rd_req && r_state == S_RDATA) begin
                // Register file answers combinationally during the request cycle.
                r_shift   <= {i_rd_data[6:0], 1'b0};
                r_siod_oe <= ~i_rd_data[7];
            end else if (w_sioc_rise) begin
                case (r_state)
                    S_DEV, S_SUB, S_WDATA: begin
                        if (r_bit_cnt != 4'd8) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                if (r_state == S_DEV) begin
                                    if (w_byte[7:1] == DEV_ADDR) begin
                                        r_rw <= w_byte[0];
                                    end else begin
                                        // Count is now 8, so the NACK bit wraps it to 0.
                                        r_err   <= 1'b1;
                                        r_state <= S_WAIT_STOP;
                                    end
                                end else if (r_state == S_SUB) begin
                                    r_wr_addr <= w_byte;
                                end else begin
                                    r_wr_data  <= w_byte;
                                    r_wr_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (r_bit_cnt != 4'd8) r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    S_RD_MACK: begin
                        // Master ACK or NACK: only one byte is ever returned.
                        r_state   <= S_WAIT_STOP;
                        r_bit_cnt <= 4'd0;
                    end
                    S_WAIT_STOP: begin
                        r_bit_cnt <= (r_bit_cnt == 4'd8) ? 4'd0 : r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) r_err <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_sioc_fall) begin
                case (r_state)
                    S_DEV: if (r_bit_cnt == 4'd8) begin
                        r_siod_oe <= 1'b1;
                        r_state   <= S_DEV_ACK;
                    end
                    S_SUB: if (r_bit_cnt == 4'd8) begin
                        r_siod_oe <= 1'b1;
                        r_state   <= S_SUB_ACK;
                    end
                    S_WDATA: if (r_bit_cnt == 4'd8) begin
                        r_siod_oe <= 1'b1;
                        r_state   <= S_WDATA_ACK;
                    end
                    S_DEV_ACK: begin
                        r_siod_oe <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        if (r_rw) begin
                            r_state  <= S_RDATA;
                            r_rd_req <= 1'b1;
                        end else begin
                            r_state <= S_SUB;
                        end
                    end
                    S_SUB_ACK: begin
                        r_siod_oe <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_WDATA;
                    end
                    S_WDATA_ACK: begin
                        r_siod_oe <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_WAIT_STOP;
                    end
                    S_RDATA: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_siod_oe <= 1'b0;
                            r_state   <= S_RD_MACK;
                        end else begin
                            r_siod_oe <= ~r_shift[7];
                            r_shift   <= {r_shift[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_siod_oe  = r_siod_oe;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_rd_req   = r_rd_req;
    assign o_busy     = r_busy;
    assign o_err      = r_err;

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- Synthesizable SCCB/I2C target (camera-side responder) for the OV7670 bus that the camera-init master drives.
- Oversamples SIOC/SIOD, decodes 3-phase write transactions (ID, sub-address, data) and 2-phase read transactions, drives ACK and read data open-drain.
- Presents register accesses to a local register file.
- Used as the on-chip bus model for self-checking init benches and as a loopback target in FPGA bring-up.

Parameters:
- DEV_ADDR, 7'h21, 7-bit target ID; write byte 0x42, read byte 0x43.
- SYNC_STAGES, 2, synchronizer depth on i_sioc/i_siod; legal range 2-3.

Ports:
- i_clk  in  1  system clock; must be at least 16x the SIOC frequency (27 MHz vs 400 kHz gives ~67x).
- i_rst  in  1  synchronous, active-high reset.
- i_sioc  in  1  bus clock, raw.
- i_siod  in  1  bus data, raw (resolved wire level).
- o_siod_oe  out  1  1 = pull SIOD low; 0 = release.
- o_wr_valid  out  1  one-cycle pulse, register write.
- o_wr_addr  out  8  sub-address for write and read.
- o_wr_data  out  8  write data, valid with o_wr_valid.
- o_rd_req  out  1  one-cycle pulse requesting read data.
- i_rd_data  in  8  read data; combinational from register file, sampled 1 cycle after o_rd_req.
- o_busy  out  1  high from START until STOP.
- o_err  out  1  one-cycle pulse on ID mismatch or unexpected extra byte.

Behaviour:
- Reset: all outputs 0, o_wr_addr = 0x00, state IDLE. Reset mid-transaction abandons the transfer; the bus is ignored until the next START.
- Input conditioning: SYNC_STAGES flops plus one history flop per line. Edges are detected on the synchronized signals. Fixed 3-cycle input latency.
- START: SIOD falls while SIOC high. From any state (repeated START included) go to DEV, bit count 0, o_busy = 1.
- STOP: SIOD rises while SIOC high. From any state go to IDLE, o_siod_oe = 0, o_busy = 0.
- Data bits are sampled on the SIOC rising edge, MSB first, 8 bits then the 9th (ACK) bit.
- Target-driven SIOD changes only on the cycle after a SIOC falling edge.
- States: IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP.
- DEV:
  - On the 8th bit, compare bits [7:1] to DEV_ADDR.
  - Match: on the following SIOC fall, set o_siod_oe = 1 (ACK) and go to DEV_ACK.
  - Mismatch: o_err pulse, stay released, go to WAIT_STOP.
- ACK release: o_siod_oe drops on the SIOC fall ending the 9th bit.
- After DEV_ACK: R/W = 0 goes to SUB; R/W = 1 goes to RDATA.
- SUB: the 8th bit latches o_wr_addr. ACK, then go to WDATA.
- WDATA: on the cycle the 8th bit is sampled, o_wr_data is loaded and o_wr_valid pulses. ACK, then go to WAIT_STOP.
- WAIT_STOP:
  - Any further full byte is not ACKed and pulses o_err on its 8th bit.
  - Only STOP or START leave this state.
- A STOP after SUB_ACK without data is legal (sets the read pointer). No write is issued.
- RDATA:
  - o_rd_req pulses on the SIOC fall that ends DEV_ACK, and i_rd_data is captured the next cycle.
  - Each bit: o_siod_oe = ~bit, updated after each SIOC fall, starting with the same fall that releases ACK.
  - After 8 bits, release SIOD and go to RD_MACK.
- RD_MACK: sample the master ACK/NACK; either value goes to WAIT_STOP. Single-byte reads only.
- o_wr_addr is unchanged by reads. No auto-increment.
- A START/STOP detected at the same cycle as a SIOC edge: the START/STOP takes priority.
- A SIOC rising edge in IDLE is ignored.

Test Plan:
- Write transaction.
  - Stimulus: START, 0x42, 0x12, 0x80, STOP at 400 kHz.
  - Required: exactly one o_wr_valid with addr 0x12, data 0x80; SIOD low during all three ACK bits; o_busy falls within 3 cycles of STOP.
- Wrong ID.
  - Stimulus: START, 0x60, 0x12, 0x80, STOP.
  - Required: o_siod_oe never high; one o_err pulse at bit 8; no o_wr_valid; a second o_err at each following byte.
- Read.
  - Stimulus: START, 0x42, 0x0A, STOP, then START, 0x43, master NACK, STOP with i_rd_data = 0x76.
  - Required: o_rd_req once; SIOD bit sequence 0,1,1,1,0,1,1,0; o_wr_addr stays 0x0A; no o_wr_valid.
- Repeated START.
  - Stimulus: START, 0x42, 0x3A, repeated START, 0x42, 0x3B, 0x04, STOP.
  - Required: a single write with addr 0x3B, data 0x04.
- Reset mid-op.
  - Stimulus: assert i_rst for 1 cycle during the SUB byte while the target is ACK-driving.
  - Required: next cycle all outputs 0; remaining bits of that transaction ignored; the next full write is decoded correctly.
- Extra byte.
  - Stimulus: START, 0x42, 0x11, 0x01, 0x55, STOP.
  - Required: one write 0x11 = 0x01; o_err on the 4th byte; no ACK on the 4th byte.
